// File: rtl/sdram_arbiter.sv
// Front end for the Tang Nano 20k SDRAM controller: 16-bit CPU req/ack bus to 32-bit
// accesses, auto-refresh scheduling and arbitration. SDRAM_ARB_WATCHDOG_EN adds an access watchdog.
module sdram_arbiter #(
  parameter int unsigned REFRESH_CYCLES = 624,
  parameter int unsigned MAX_PENDING    = 3,
  parameter int unsigned URGENT_PENDING = 2,
  parameter int unsigned WDOG_CYCLES    = 63
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [21:0] cpu_addr_i,
  input  logic        cpu_uds_i,
  input  logic        cpu_lds_i,
  input  logic [15:0] cpu_din_i,
  output logic [15:0] cpu_dout_o,
  output logic        cpu_ack_o,
  input  logic        sdr_ready_i,
  input  logic        sdr_cmd_ready_i,
  input  logic [31:0] sdr_dout_i,
  input  logic        sdr_dout_valid_i,
  output logic        sdr_cs_o,
  output logic        sdr_we_o,
  output logic        sdr_refresh_o,
  output logic [20:0] sdr_addr_o,
  output logic [3:0]  sdr_ds_o,
  output logic [31:0] sdr_din_o,
  output logic        wdog_err_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RELEASE} state_t;

  localparam logic [9:0] RELOAD = 10'(REFRESH_CYCLES - 1);
  localparam logic [1:0] MAX_P  = 2'(MAX_PENDING);
  localparam logic [1:0] URG_P  = 2'(URGENT_PENDING);

  state_t      state;
  logic [9:0]  refresh_cnt;
  logic [1:0]  pending;
  logic        tick;
  logic        grant_refresh;
  logic        grant_cpu;
  logic        is_write;
  logic        is_refresh;
  logic        half_sel;
  logic        armed;
  logic        captured;
  logic [15:0] rd_half;
  logic [15:0] rd_now;
  logic        busy;
  logic        done;
  logic        wdog_fire;

  assign tick   = (refresh_cnt == '0);
  assign rd_now = half_sel ? sdr_dout_i[15:0] : sdr_dout_i[31:16];
  assign busy   = (state == ISSUE) || (state == WAIT);
  // Data strobe and cmd_ready rising together both count toward completion.
  assign done   = (state == WAIT) && sdr_cmd_ready_i &&
                  (is_write || is_refresh || captured || (armed && sdr_dout_valid_i));

  always_comb begin
    grant_refresh = 1'b0;
    grant_cpu     = 1'b0;
    if (state == IDLE && sdr_ready_i && sdr_cmd_ready_i) begin
      if (pending >= URG_P)      grant_refresh = 1'b1;
      else if (cpu_req_i)        grant_cpu     = 1'b1;
      else if (pending != '0)    grant_refresh = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      refresh_cnt <= RELOAD;
      pending     <= '0;
    end else begin
      refresh_cnt <= tick ? RELOAD : refresh_cnt - 10'd1;
      if (tick && !grant_refresh) begin
        if (pending < MAX_P) pending <= pending + 2'd1;
      end else if (!tick && grant_refresh) begin
        pending <= pending - 2'd1;
      end
    end
  end

`ifdef SDRAM_ARB_WATCHDOG_EN
  logic [5:0] wdog_cnt;

  assign wdog_fire = busy && !done && (wdog_cnt == 6'(WDOG_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wdog_cnt   <= '0;
      wdog_err_o <= 1'b0;
    end else begin
      wdog_cnt <= busy ? wdog_cnt + 6'd1 : '0;
      if (wdog_fire) wdog_err_o <= 1'b1;
    end
  end
`else
  assign wdog_fire  = 1'b0;
  assign wdog_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state         <= IDLE;
      sdr_cs_o      <= 1'b0;
      sdr_we_o      <= 1'b0;
      sdr_refresh_o <= 1'b0;
      sdr_addr_o    <= '0;
      sdr_ds_o      <= '0;
      sdr_din_o     <= '0;
      cpu_ack_o     <= 1'b0;
      cpu_dout_o    <= '0;
      is_write      <= 1'b0;
      is_refresh    <= 1'b0;
      half_sel      <= 1'b0;
      armed         <= 1'b0;
      captured      <= 1'b0;
      rd_half       <= '0;
    end else begin
      case (state)
        IDLE: begin
          armed    <= 1'b0;
          captured <= 1'b0;
          if (grant_refresh) begin
            sdr_cs_o      <= 1'b1;
            sdr_refresh_o <= 1'b1;
            sdr_we_o      <= 1'b0;
            sdr_ds_o      <= '0;
            sdr_addr_o    <= '0;
            sdr_din_o     <= '0;
            is_refresh    <= 1'b1;
            is_write      <= 1'b0;
            state         <= ISSUE;
          end else if (grant_cpu) begin
            sdr_cs_o      <= 1'b1;
            sdr_refresh_o <= 1'b0;
            sdr_we_o      <= cpu_we_i;
            sdr_addr_o    <= cpu_addr_i[21:1];
            sdr_ds_o      <= cpu_addr_i[0] ? {2'b00, cpu_uds_i, cpu_lds_i}
                                           : {cpu_uds_i, cpu_lds_i, 2'b00};
            sdr_din_o     <= {cpu_din_i, cpu_din_i};
            is_refresh    <= 1'b0;
            is_write      <= cpu_we_i;
            half_sel      <= cpu_addr_i[0];
            state         <= ISSUE;
          end
        end
        ISSUE, WAIT: begin
          if (state == WAIT && armed && sdr_dout_valid_i && !captured) begin
            rd_half  <= rd_now;
            captured <= 1'b1;
          end
          if (done) begin
            sdr_cs_o      <= 1'b0;
            sdr_refresh_o <= 1'b0;
            cpu_ack_o     <= !is_refresh;
            cpu_dout_o    <= (is_write || is_refresh) ? '0 : (captured ? rd_half : rd_now);
            state         <= RELEASE;
          end else if (wdog_fire) begin
            sdr_cs_o      <= 1'b0;
            sdr_refresh_o <= 1'b0;
            cpu_ack_o     <= !is_refresh;
            cpu_dout_o    <= is_refresh ? '0 : '1;
            state         <= RELEASE;
          end else if (state == ISSUE && !sdr_cmd_ready_i) begin
            armed <= !is_write && !is_refresh;
            state <= WAIT;
          end
        end
        RELEASE: begin
          cpu_ack_o  <= 1'b0;
          cpu_dout_o <= '0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
